// File: rtl/lsu_pkg.sv
// Shared LSU definitions: access sizes, store masks, FSM states.
// Imported by the memory controller and the load extender.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_e;

  // Natural alignment: low size bits of the address must be zero
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      size == SZ_H: m = lo[0];
      size == SZ_W: m = |lo[1:0];
      size == SZ_D: m = |lo[2:0];
      default:      m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data size extension (sign or zero).
// Purely combinational; shared with writeback.
module lsu_load_ext (
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [63:0] raw,
  output logic [63:0] ext
);
  import lsu_pkg::*;

  logic sb;
  logic sh;
  logic sw;

  assign sb = ~uns & raw[7];
  assign sh = ~uns & raw[15];
  assign sw = ~uns & raw[31];

  // Replicate the access's top bit, or zeros for unsigned loads
  always_comb begin
    ext = raw;
    unique case (1'b1)
      size == SZ_B: ext = {{56{sb}}, raw[7:0]};
      size == SZ_H: ext = {{48{sh}}, raw[15:0]};
      size == SZ_W: ext = {{32{sw}}, raw[31:0]};
      default:      ext = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the data memory port.
// One access in flight; misaligned requests answer without issue.
module lsu_mem_ctrl #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_misalign,
  output logic        mem_rd_en,
  output logic [63:0] mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        mem_we_en,
  output logic [63:0] mem_we_addr,
  output logic [63:0] mem_we_data,
  output logic [7:0]  mem_we_mask
);
  import lsu_pkg::*;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  lsu_state_e  state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [3:0]  cnt;
  logic [63:0] ld_ext;
  logic [7:0]  mask;
  logic [63:0] wbits;
  logic        in_req;
  logic        is_ld;
  logic        is_st;
  logic        last;

  lsu_load_ext u_ext (
    .size (size_q),
    .uns  (uns_q),
    .raw  (mem_rd_data),
    .ext  (ld_ext)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign in_req     = (state == ST_REQ);
  assign is_ld      = in_req & ~write_q;
  assign is_st      = in_req & write_q;
  assign last       = (cnt == 4'd0);

  // Byte mask of the store, from the latched size
  always_comb begin
    mask = MASK_D;
    unique case (1'b1)
      size_q == SZ_B: mask = MASK_B;
      size_q == SZ_H: mask = MASK_H;
      size_q == SZ_W: mask = MASK_W;
      default:        mask = MASK_D;
    endcase
  end

  // Expand the byte mask to a bit mask for store data
  always_comb begin
    wbits = '0;
    for (int i = 0; i < 8; i++) begin
      wbits[i*8 +: 8] = {8{mask[i]}};
    end
  end

  assign mem_rd_en   = is_ld;
  assign mem_rd_addr = is_ld ? addr_q : '0;
  assign mem_we_en   = is_st & last;
  assign mem_we_addr = is_st ? addr_q : '0;
  assign mem_we_data = is_st ? (wdata_q & wbits) : '0;
  assign mem_we_mask = is_st ? mask : '0;

  // Access FSM: accept, hold the port for the latency, respond
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      size_q        <= '0;
      uns_q         <= 1'b0;
      cnt           <= '0;
      resp_rdata    <= '0;
      resp_misalign <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            write_q    <= req_write;
            size_q     <= req_size;
            uns_q      <= req_unsigned;
            resp_rdata <= '0;
            if (misaligned(req_size, req_addr[2:0])) begin
              resp_misalign <= 1'b1;
              state         <= ST_RESP;
            end else begin
              resp_misalign <= 1'b0;
              cnt           <= LAT_M1;
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (last) begin
            resp_rdata <= write_q ? '0 : ld_ext;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized scoreboard bench for lsu_mem_ctrl.
// Driver pushes expectations; a negedge monitor checks them.
module tb_lsu_mem_ctrl;

  localparam int LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic [63:0] mem_rd_data;
  logic        mem_we_en;
  logic [63:0] mem_we_addr;
  logic [63:0] mem_we_data;
  logic [7:0]  mem_we_mask;

  logic [63:0] rd_pattern = '0;
  assign mem_rd_data = rd_pattern;

  always #5 clock = ~clock;

  lsu_mem_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_write     (req_write),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_misalign (resp_misalign),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .mem_we_en     (mem_we_en),
    .mem_we_addr   (mem_we_addr),
    .mem_we_data   (mem_we_data),
    .mem_we_mask   (mem_we_mask)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [7:0]  mask;
    logic        write;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   we_total = 0;
  int   rd_cnt = 0;
  int   we_cnt = 0;
  int   hold = 0;
  bit   seen = 0;

  always @(posedge clock) cyc++;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: natural alignment, shift-based extension
  function automatic exp_t model(logic [63:0] addr,
                                 logic [63:0] wdata,
                                 logic write, logic [1:0] size,
                                 logic uns, logic [63:0] raw);
    exp_t e;
    int nbytes;
    int sh;
    logic signed [63:0] s;
    nbytes  = 1 << size;
    sh      = 64 - 8 * nbytes;
    e.addr  = addr;
    e.write = write;
    e.mis   = (addr % 64'(nbytes)) != 0;
    e.wdata = (wdata << sh) >> sh;
    e.mask  = 8'((16'd1 << nbytes) - 16'd1);
    s       = raw << sh;
    s       = s >>> sh;
    if (e.mis || write) e.rdata = '0;
    else if (uns)       e.rdata = (raw << sh) >> sh;
    else                e.rdata = s;
    e.lat = e.mis ? 1 : LAT + 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(logic [63:0] addr, logic [63:0] wdata,
                       logic write, logic [1:0] size,
                       logic uns, logic [63:0] raw);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clock);
    while (!req_ready) begin
      @(negedge clock);
      guard++;
      if (guard > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL req_ready_timeout: got 0 expected 1");
        return;
      end
    end
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = wdata;
    req_write    = write;
    req_size     = size;
    req_unsigned = uns;
    rd_pattern   = raw;
    e = model(addr, wdata, write, size, uns, raw);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
  endtask

  // Monitor: port checks every cycle, response checks on valid
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      rd_cnt = 0;
      we_cnt = 0;
      seen   = 0;
    end else begin
      chk("rd_we_excl", 64'(mem_rd_en & mem_we_en), 0);
      if (mem_rd_en) begin
        rd_cnt++;
        if (q.size() > 0)
          chk("rd_addr", mem_rd_addr, q[0].addr);
      end
      if (mem_we_en) begin
        we_cnt++;
        we_total++;
        if (q.size() > 0) begin
          chk("we_addr", mem_we_addr, q[0].addr);
          chk("we_data", mem_we_data, q[0].wdata);
          chk("we_mask", 64'(mem_we_mask), 64'(q[0].mask));
        end
      end
      if (req_ready || resp_valid)
        chk("mem_quiet",
            64'({mem_rd_en, mem_we_en}) | mem_rd_addr |
            mem_we_addr | mem_we_data | 64'(mem_we_mask), 0);
      if (resp_valid) begin
        chk("req_ready_in_resp", 64'(req_ready), 0);
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got 1 expected 0");
          resp_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1;
            chk("latency", 64'(cyc - q[0].acc + 1),
                64'(q[0].lat));
          end
          chk("resp_rdata", resp_rdata, q[0].rdata);
          chk("resp_misalign", 64'(resp_misalign),
              64'(q[0].mis));
          if (hold > 0) begin
            resp_ready = 1'b0;
            hold--;
          end else begin
            resp_ready = ($urandom_range(0, 99) < 60);
          end
          if (resp_ready) begin
            chk("rd_cycles", 64'(rd_cnt),
                (q[0].mis || q[0].write) ? 0 : 64'(LAT));
            chk("we_cycles", 64'(we_cnt),
                (!q[0].mis && q[0].write) ? 1 : 0);
            void'(q.pop_front());
            rd_cnt = 0;
            we_cnt = 0;
            seen   = 0;
          end
        end
      end else begin
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_mis"}, 64'(resp_misalign), 0);
    chk({tag, "_mem"},
        64'({mem_rd_en, mem_we_en}) | mem_rd_addr |
        mem_we_addr | mem_we_data | 64'(mem_we_mask), 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               q.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    int          w0;
    repeat (3) @(negedge clock);
    check_reset_outputs("init");
    reset = 1'b0;

    issue(64'h80000003, '0, 0, 2'd0, 0, 64'h123456789ABCDEF0);
    issue(64'h80000003, '0, 0, 2'd0, 1, 64'h123456789ABCDEF0);
    issue(64'h80000004, 64'h1122334455667788, 1, 2'd2, 0, '0);
    issue(64'h80000002, '0, 0, 2'd2, 0, 64'hFFFF0000FFFF0000);
    issue(64'h80000008, 64'hA5A5A5A5_5A5A5A5A, 1, 2'd3, 0, '0);
    issue(64'h80000010, '0, 0, 2'd3, 0, 64'h8000000000000001);
    issue(64'h80000006, '0, 0, 2'd1, 0, 64'h0000000000008001);
    issue(64'h80000004, '0, 0, 2'd2, 1, 64'hFFFFFFFF80000000);
    issue(64'h80000005, 64'h1234, 1, 2'd1, 0, '0);
    drain();
    hold = 3;
    issue(64'h80000020, '0, 0, 2'd2, 0, 64'h00000000F0000000);
    drain();

    for (int i = 0; i < 300; i++) begin
      a  = {32'h80000000, 32'($urandom)};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0)
        a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      issue(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            sz, 1'($urandom_range(0, 1)),
            {$urandom, $urandom});
    end
    drain();

    issue(64'h80000040, 64'hDEADBEEFCAFEF00D, 1, 2'd3, 0, '0);
    w0 = we_total;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreq");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("we_after_reset", 64'(we_total), 64'(w0));
    chk("post_reset_ready", 64'(req_ready), 1);

    issue(64'h80000050, '0, 0, 2'd1, 1, 64'h000000000000FFEE);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
